spi_master_param: RTL

//   Parametrised full-duplex SPI master: DATA_W-bit frames, run-time CPOL/CPHA (modes 0-3),

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_master_param_clk_div.sv | 40 ++++
 rtl/spi_master_param.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding, SPI mode encoding
// and the chip-select index width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        FIN
    } state_e;

    // Mode number is {cpol, cpha}.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    function automatic int cs_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_param_clk_div.sv
// SCLK half-period timer: counts CLK_DIV clk cycles and emits a one-cycle
// tick at the end of each half-period; clr restarts the count on state entry.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // tick must not depend on clr: clr is derived from the next state, which uses tick.
    assign tick = en && (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master, run-time modes 0-3, one-hot active-low chip selects.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input (RX takes MOSI).
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CS_N    = 1,
    parameter int CLK_DIV = 4,
    localparam int CS_SEL_W = cs_sel_w(CS_N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic [DATA_W-1:0]   data_in,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                loopback,
`endif
    output logic                ready,
    output logic                done,
    output logic [DATA_W-1:0]   data_out,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [CS_N-1:0]     cs_n
);

    localparam int EDGES  = 2 * DATA_W;
    localparam int EDGE_W = $clog2(EDGES + 1);

    state_e                state_q, state_d;
    spi_mode_e             mode_q, mode_d;
    logic [CS_SEL_W-1:0]   cs_sel_q, cs_sel_d;
    logic [DATA_W-1:0]     tx_q, tx_d;
    logic [DATA_W-1:0]     rx_q, rx_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic                  sclk_q, sclk_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic                  lb_q, lb_d;

    logic                  tick;
    logic                  div_en;
    logic                  div_clr;
    logic [EDGE_W-1:0]     edge_k;
    logic                  leading;
    logic                  sample;
    logic                  rx_bit;

    assign div_en  = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
    assign div_clr = (state_d != state_q);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr),
        .tick (tick)
    );

    assign edge_k  = edge_q + EDGE_W'(1);
    assign leading = edge_k[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    assign sample  = leading ^ mode_q[0];
    assign rx_bit  = lb_q ? tx_q[DATA_W-1] : miso;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cs_sel_d   = cs_sel_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        sclk_d     = sclk_q;
        edge_d     = edge_q;
        lb_d       = lb_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = spi_mode_e'({cpol, cpha});
                    cs_sel_d = cs_sel;
                    tx_d     = data_in;
                    rx_d     = '0;
                    sclk_d   = cpol;
                    edge_d   = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
                    lb_d     = loopback;
`else
                    lb_d     = 1'b0;
`endif
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_k;
                    if (sample) begin
                        rx_d = {rx_q[DATA_W-2:0], rx_bit};
                    end else if (edge_k != EDGE_W'(1) && edge_k != EDGE_W'(EDGES)) begin
                        tx_d = tx_q << 1;
                    end
                    if (edge_k == EDGE_W'(EDGES)) state_d = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    data_out_d = rx_q;
                    state_d    = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE0;
            cs_sel_q   <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            sclk_q     <= 1'b0;
            edge_q     <= '0;
            lb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cs_sel_q   <= cs_sel_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            sclk_q     <= sclk_d;
            edge_q     <= edge_d;
            lb_q       <= lb_d;
        end
    end

    // An out-of-range index matches no line, so every select stays high.
    always_comb begin
        cs_n = '1;
        if (div_en && !lb_q) begin
            for (int i = 0; i < CS_N; i++) begin
                if (cs_sel_q == CS_SEL_W'(i)) cs_n[i] = 1'b0;
            end
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = (state_q == FIN);
    assign data_out = data_out_q;
    assign sclk     = sclk_q;
    assign mosi     = tx_q[DATA_W-1];

endmodule
